// File: rtl/render_scheduler_pkg.sv
// Shared types and constants for the render scheduler: FSM state encoding,
// layer indices used on the sprite-code memory port, and the layer code
// values loaded when a pixel starts.
package render_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] LAYER_JOGADOR = 3'd0;
    localparam logic [2:0] LAYER_OP1     = 3'd1;
    localparam logic [2:0] LAYER_OP2     = 3'd2;
    localparam logic [2:0] LAYER_OP3     = 3'd3;
    localparam logic [2:0] LAYER_FUNDO   = 3'd4;

    localparam logic [2:0] TRANSP      = 3'b111;
    localparam logic [2:0] FUNDO_RESET = 3'b000;

endpackage

// File: rtl/render_scheduler_pixel_scan_counter.sv
// Raster x/y counter for the active frame. clear returns to (0,0);
// advance steps x and wraps to the next line at the end of each line.
// last_pixel flags the bottom-right pixel of the frame.
module pixel_scan_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       last_pixel
);

    logic x_last;
    logic y_last;

    assign x_last     = (x == 10'(H_ACTIVE - 1));
    assign y_last     = (y == 9'(V_ACTIVE - 1));
    assign last_pixel = x_last && y_last;

    // Raster position: restart on clear, otherwise step on advance with line wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? 9'd0 : y + 9'd1;
            end else begin
                x <= x + 10'd1;
            end
        end
    end

endmodule

// File: rtl/render_scheduler.sv
// Frame-fill controller for the pixel renderer. Walks the active frame in
// raster order, fetches the five layer codes of each pixel from the shared
// sprite-code memory and hands the finished pixel to the framebuffer writer.
// Build option RENDER_EARLY_EXIT_EN: when defined, fetching stops at the
// first opaque sprite layer; when undefined, all five layers are always
// fetched and the registers hold the raw memory codes.
module render_scheduler #(
    parameter int         H_ACTIVE = 640,
    parameter int         V_ACTIVE = 480,
    parameter logic [2:0] TRANSP   = 3'b111
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       frame_done,
    output logic       mem_rd_en,
    output logic [2:0] mem_layer,
    output logic [9:0] mem_x,
    output logic [8:0] mem_y,
    input  logic       mem_gnt,
    input  logic [2:0] mem_rdata,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [2:0] jogador,
    output logic [2:0] oponente1,
    output logic [2:0] oponente2,
    output logic [2:0] oponente3,
    output logic [2:0] fundo,
    output logic       pix_valid,
    input  logic       pix_ready
);

    import render_pkg::*;

    state_t     state;
    logic [2:0] layer;
    logic       scan_clear;
    logic       scan_advance;
    logic       last_pixel;
    logic       early_exit;

    // Raster restarts when a frame is accepted and steps on every handshake
    // except the last one, so x/y stay on the final pixel through DONE.
    assign scan_clear   = (state == IDLE) && start;
    assign scan_advance = (state == OUT) && pix_ready && !last_pixel;

    assign mem_layer = layer;
    assign mem_x     = x;
    assign mem_y     = y;

`ifdef RENDER_EARLY_EXIT_EN
    // An opaque sprite hides everything beneath it, so stop fetching there.
    assign early_exit = (mem_rdata != TRANSP);
`else
    assign early_exit = 1'b0;
`endif

    pixel_scan_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_scan (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (scan_clear),
        .advance    (scan_advance),
        .x          (x),
        .y          (y),
        .last_pixel (last_pixel)
    );

    // Frame sequencing FSM with registered control outputs and layer code registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            layer      <= LAYER_JOGADOR;
            jogador    <= TRANSP;
            oponente1  <= TRANSP;
            oponente2  <= TRANSP;
            oponente3  <= TRANSP;
            fundo      <= FUNDO_RESET;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            mem_rd_en  <= 1'b0;
            pix_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        state     <= FETCH;
                        layer     <= LAYER_JOGADOR;
                        jogador   <= TRANSP;
                        oponente1 <= TRANSP;
                        oponente2 <= TRANSP;
                        oponente3 <= TRANSP;
                        fundo     <= FUNDO_RESET;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                    end
                end
                FETCH: begin
                    // Request holds unchanged until the arbiter grants it
                    if (mem_gnt) begin
                        mem_rd_en <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    case (layer)
                        LAYER_JOGADOR: jogador   <= mem_rdata;
                        LAYER_OP1:     oponente1 <= mem_rdata;
                        LAYER_OP2:     oponente2 <= mem_rdata;
                        LAYER_OP3:     oponente3 <= mem_rdata;
                        default:       fundo     <= mem_rdata;
                    endcase
                    if ((layer == LAYER_FUNDO) || early_exit) begin
                        state     <= OUT;
                        pix_valid <= 1'b1;
                    end else begin
                        layer     <= layer + 3'd1;
                        state     <= FETCH;
                        mem_rd_en <= 1'b1;
                    end
                end
                OUT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (last_pixel) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            state     <= FETCH;
                            layer     <= LAYER_JOGADOR;
                            jogador   <= TRANSP;
                            oponente1 <= TRANSP;
                            oponente2 <= TRANSP;
                            oponente3 <= TRANSP;
                            fundo     <= FUNDO_RESET;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    frame_done <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Bench for render_scheduler on a 4x2 frame: directed steps plus
// randomized memory contents and grant/ready patterns, checked against a
// transaction-level model of the expected request and pixel streams.
module tb_render_scheduler;

    localparam int         H    = 4;
    localparam int         V    = 2;
    localparam int         NPIX = H * V;
    localparam logic [2:0] TR   = 3'b111;
`ifdef RENDER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       busy;
    logic       frame_done;
    logic       mem_rd_en;
    logic [2:0] mem_layer;
    logic [9:0] mem_x;
    logic [8:0] mem_y;
    logic       mem_gnt;
    logic [2:0] mem_rdata;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] jogador, oponente1, oponente2, oponente3, fundo;
    logic       pix_valid;
    logic       pix_ready;
    logic [14:0] codes;

    assign codes = {jogador, oponente1, oponente2, oponente3, fundo};

    render_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .TRANSP(TR)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
        .frame_done(frame_done), .mem_rd_en(mem_rd_en), .mem_layer(mem_layer),
        .mem_x(mem_x), .mem_y(mem_y), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .x(x), .y(y), .jogador(jogador), .oponente1(oponente1),
        .oponente2(oponente2), .oponente3(oponente3), .fundo(fundo),
        .pix_valid(pix_valid), .pix_ready(pix_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [2:0] l; logic [9:0] x; logic [8:0] y; } req_t;
    typedef struct packed { logic [9:0] x; logic [8:0] y; logic [14:0] c; } pix_t;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   frames = 0;
    int   last_cyc = 0;
    logic [2:0] tab [0:4][0:NPIX-1];
    req_t req_q[$];
    pix_t pix_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected streams for one frame, derived from the layer table
    task automatic build_model();
        req_q.delete();
        pix_q.delete();
        for (int p = 0; p < NPIX; p++) begin
            logic [14:0] e;
            e = {TR, TR, TR, TR, 3'b000};
            for (int l = 0; l < 5; l++) begin
                req_q.push_back(req_t'{3'(l), 10'(p % H), 9'(p / H)});
                e[14 - 3*l -: 3] = tab[l][p];
                if (EE && l < 4 && tab[l][p] != TR) break;
            end
            pix_q.push_back(pix_t'{10'(p % H), 9'(p / H), e});
        end
    endtask

    // Sprite-code memory: data one cycle after grant, junk otherwise
    always @(posedge clk) begin
        if (mem_rd_en && mem_gnt)
            mem_rdata <= tab[mem_layer][int'(mem_y) * H + int'(mem_x)];
        else
            mem_rdata <= 3'($urandom);
    end

    logic        p_valid = 1'b0, p_ready = 1'b0, p_rd = 1'b0, p_gnt = 1'b0, p_done = 1'b0;
    logic [9:0]  p_x;
    logic [8:0]  p_y;
    logic [2:0]  p_l;
    logic [14:0] p_codes;

    // Protocol and stream monitor, sampled just after the falling edge
    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            p_valid = 1'b0;
            p_rd    = 1'b0;
            p_done  = 1'b0;
        end else begin
            req_t er;
            pix_t ep;
            if (p_valid && !p_ready) begin
                check("valid_hold", 64'(pix_valid), 64'(1));
                check("pix_hold", 64'({x, y, codes}), 64'({p_x, p_y, p_codes}));
            end
            if (p_rd && !p_gnt)
                check("req_hold", 64'({mem_rd_en, mem_layer, mem_x, mem_y}), 64'({1'b1, p_l, p_x, p_y}));
            if (p_done) check("done_pulse", 64'(frame_done), 64'(0));
            if (mem_rd_en) check("rd_vs_valid", 64'(pix_valid), 64'(0));
            if (frame_done) begin
                done_cnt++;
                check("done_busy", 64'(busy), 64'(0));
                check("done_queues", 64'(req_q.size() + pix_q.size()), 64'(0));
            end
            if (mem_rd_en && mem_gnt) begin
                er = '1;
                if (req_q.size() > 0) er = req_q.pop_front();
                check("req", 64'({mem_layer, mem_x, mem_y}), 64'(er));
            end
            if (pix_valid && pix_ready) begin
                ep = '1;
                if (pix_q.size() > 0) ep = pix_q.pop_front();
                check("pixel", 64'({x, y, codes}), 64'(ep));
            end
            p_valid = pix_valid; p_ready = pix_ready; p_rd = mem_rd_en; p_gnt = mem_gnt;
            p_done = frame_done; p_x = x; p_y = y; p_l = mem_layer; p_codes = codes;
        end
    end

    task automatic run_frame(input bit rnd, input bit poke);
        int cyc;
        int n_req;
        build_model();
        n_req = req_q.size();
        frames++;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        cyc = 0;
        while (!frame_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (rnd) begin
                mem_gnt   = 1'($urandom_range(0, 1));
                pix_ready = 1'($urandom_range(0, 1));
            end
            start = (poke && cyc == 5);
        end
        last_cyc = cyc;
        check("frame_done_seen", 64'(frame_done), 64'(1));
        if (!rnd) check("frame_cycles", 64'(cyc), 64'(2 * n_req + NPIX));
        mem_gnt   = 1'b1;
        pix_ready = 1'b1;
        if (poke) begin
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            repeat (12) begin
                @(negedge clk);
                check("idle_after_done", 64'({busy, mem_rd_en}), 64'(0));
            end
        end else begin
            @(negedge clk);
            check("idle", 64'(busy), 64'(0));
        end
    endtask

    initial begin
        int   saved_done;
        logic [33:0] saved;
        reset_n = 1'b0; start = 1'b0; mem_gnt = 1'b1; pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 64'({busy, frame_done, mem_rd_en, pix_valid, x, y, codes}),
              64'({4'b0, 10'd0, 9'd0, TR, TR, TR, TR, 3'b000}));
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);

        // Opaque jogador everywhere; start poked while busy and in DONE
        for (int p = 0; p < NPIX; p++) begin
            tab[0][p] = 3'b101; tab[1][p] = 3'b001; tab[2][p] = 3'b001;
            tab[3][p] = 3'b001; tab[4][p] = 3'b110;
        end
        run_frame(1'b0, 1'b1);
        check("t1_cycles", 64'(last_cyc), 64'(EE ? 24 : 88));
        check("t1_one_done", 64'(done_cnt), 64'(1));

        // All sprites transparent, background 010
        for (int p = 0; p < NPIX; p++) begin
            for (int l = 0; l < 4; l++) tab[l][p] = TR;
            tab[4][p] = 3'b010;
        end
        run_frame(1'b0, 1'b0);
        check("t2_cycles", 64'(last_cyc), 64'(88));

        // Grant stall on layer 2, ready stall at line end, then mid-frame reset
        tab[2][0] = 3'b011;
        build_model();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 50 && !(mem_rd_en && mem_layer == 3'd1 && x == 0 && y == 0); i++) @(negedge clk);
        check("t3_reach_l1", 64'({mem_rd_en, mem_layer}), 64'({1'b1, 3'd1}));
        @(negedge clk) mem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_req", 64'({mem_rd_en, mem_layer, mem_x, mem_y}), 64'({1'b1, 3'd2, 10'd0, 9'd0}));
        end
        mem_gnt = 1'b1;
        for (int i = 0; i < 50 && !pix_valid; i++) @(negedge clk);
        check("t3_code", 64'({pix_valid, oponente2}), 64'({1'b1, 3'b011}));

        for (int i = 0; i < 200 && !(mem_rd_en && x == 3 && y == 0); i++) @(negedge clk);
        pix_ready = 1'b0;
        for (int i = 0; i < 50 && !pix_valid; i++) @(negedge clk);
        check("t4_at_x3", 64'({pix_valid, x, y}), 64'({1'b1, 10'd3, 9'd0}));
        saved = {x, y, codes};
        repeat (6) begin
            @(negedge clk);
            check("t4_hold", 64'({pix_valid, x, y, codes}), 64'({1'b1, saved}));
        end
        pix_ready = 1'b1;
        @(negedge clk);
        check("t4_wrap", 64'({x, y}), 64'({10'd0, 9'd1}));

        for (int i = 0; i < 200 && !(mem_rd_en && x == 2 && y == 1); i++) @(negedge clk);
        check("t5_reach", 64'({x, y}), 64'({10'd2, 9'd1}));
        saved_done = done_cnt;
        reset_n = 1'b0;
        #1;
        check("t5_reset_now", 64'({busy, frame_done, mem_rd_en, pix_valid, x, y, codes}),
              64'({4'b0, 10'd0, 9'd0, TR, TR, TR, TR, 3'b000}));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_done", 64'({busy, 32'(done_cnt)}), 64'({1'b0, 32'(saved_done)}));

        // Randomized layer tables with random grant/ready
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < NPIX; p++)
                for (int l = 0; l < 5; l++)
                    tab[l][p] = ($urandom_range(0, 1) != 0) ? TR : 3'($urandom_range(0, 6));
            run_frame(1'b1, 1'b0);
        end

        check("frame_done_total", 64'(done_cnt), 64'(frames));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
